// File: rtl/countdown_timer.sv
// ============================================================================
// countdown_timer
// ----------------------------------------------------------------------------
// Game countdown timer. Counts an M:SS value, held as three BCD digits, down
// from START_MIN:START_SEC by one second per seconds tick. It reports
// run/expire status to the game control FSM.
//
// Optional feature macro: COUNTDOWN_SEG_EN
//   When it is defined, the block also drives registered active-low
//   seven-segment patterns {g,f,e,d,c,b,a} for each digit.
//
// Parameters
//   START_MIN     start minutes digit, 0..9
//   START_SEC     start seconds, 0..59
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   tick          one-cycle seconds pulse from the rate divider
//   start         start / resume request
//   pause         pause request
//   clear         reload start value and return to IDLE
//   min_bcd       minutes digit
//   sec_tens      seconds tens digit (0..5)
//   sec_ones      seconds ones digit (0..9)
//   running       high while in RUN
//   expired       high while in EXPIRED
//   expire_pulse  one-cycle strobe on entry to EXPIRED
//   hex2/1/0      segment patterns for min/tens/ones (COUNTDOWN_SEG_EN only)
// ============================================================================
module countdown_timer #(
    parameter int unsigned START_MIN = 1,
    parameter int unsigned START_SEC = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
`ifdef COUNTDOWN_SEG_EN
    output logic       expire_pulse,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0
`else
    output logic       expire_pulse
`endif
);

    localparam logic [3:0] START_M    = 4'(START_MIN);
    localparam logic [3:0] START_T    = 4'(START_SEC / 10);
    localparam logic [3:0] START_O    = 4'(START_SEC % 10);
    localparam logic       START_ZERO = (START_MIN == 0) && (START_SEC == 0);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic [1:0] r_state;
    logic [3:0] r_min, r_tens, r_ones;
    logic       r_running, r_expired, r_expire_pulse;

    logic [1:0] w_state_nxt;
    logic [3:0] w_min_nxt, w_tens_nxt, w_ones_nxt;
    logic       w_pulse_nxt;
    logic       w_last_second;

    // The value is 0:01, so the next decrement lands on 0:00.
    assign w_last_second = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

    // Next-state and next-digit logic. Priority: clear > pause > start > tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_pulse_nxt = 1'b0;

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_min_nxt   = START_M;
            w_tens_nxt  = START_T;
            w_ones_nxt  = START_O;
        end else if (pause) begin
            // pause masks start and tick in every state; only RUN reacts.
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (START_ZERO) begin
                            w_state_nxt = S_EXPIRED;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                end
                S_PAUSE: begin
                    // A resume consumes the cycle; a coincident tick is dropped.
                    if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        // BCD borrow chain, ones -> tens -> minutes.
                        if (r_ones != 4'd0) begin
                            w_ones_nxt = r_ones - 4'd1;
                        end else if (r_tens != 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end else if (r_min != 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = 4'd5;
                            w_min_nxt  = r_min - 4'd1;
                        end
                        if (w_last_second) begin
                            w_state_nxt = S_EXPIRED;
                            w_pulse_nxt = 1'b1;
                        end
                    end
                end
                default: ; // EXPIRED holds at 0:00 until clear or reset
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_min          <= START_M;
            r_tens         <= START_T;
            r_ones         <= START_O;
            r_running      <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_min          <= w_min_nxt;
            r_tens         <= w_tens_nxt;
            r_ones         <= w_ones_nxt;
            r_running      <= (w_state_nxt == S_RUN);
            r_expired      <= (w_state_nxt == S_EXPIRED);
            r_expire_pulse <= w_pulse_nxt;
        end
    end

    assign min_bcd      = r_min;
    assign sec_tens     = r_tens;
    assign sec_ones     = r_ones;
    assign running      = r_running;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;

`ifdef COUNTDOWN_SEG_EN
    // Active-low {g,f,e,d,c,b,a}; codes above 9 blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [6:0] r_hex2, r_hex1, r_hex0;

    // Decoded from the next digits so segments update on the same edge as the BCD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex2 <= seg7(START_M);
            r_hex1 <= seg7(START_T);
            r_hex0 <= seg7(START_O);
        end else begin
            r_hex2 <= seg7(w_min_nxt);
            r_hex1 <= seg7(w_tens_nxt);
            r_hex0 <= seg7(w_ones_nxt);
        end
    end

    assign hex2 = r_hex2;
    assign hex1 = r_hex1;
    assign hex0 = r_hex0;
`endif

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Game countdown timer that sits directly downstream of the 1-second rate divider. It consumes the divider's one-cycle `pulse` as a seconds tick. It counts a M:SS value in BCD down from a parameterised start time, and exposes run/expire status to the game control FSM. The three-digit value goes to the display path, with optional on-block seven-segment decoding.

## Interface
- `START_MIN`, default 1: start minutes digit, legal 0–9.
- `START_SEC`, default 30: start seconds, legal 0–59. Illegal parameter values are unsupported; the bench uses only legal values.

- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle seconds pulse from the rate divider.
- `start` input 1: one-cycle request to start or resume counting.
- `pause` input 1: one-cycle request to pause counting.
- `clear` input 1: one-cycle request to reload the start value and return to IDLE.
- `min_bcd` output 4: minutes digit.
- `sec_tens` output 4: seconds tens digit, 0–5.
- `sec_ones` output 4: seconds ones digit, 0–9.
- `running` output 1: high while in RUN.
- `expired` output 1: high while in EXPIRED.
- `expire_pulse` output 1: high for exactly one cycle on entry to EXPIRED.
- `hex2`, `hex1`, `hex0` output 7 each: active-low segments `{g,f,e,d,c,b,a}` for min, tens and ones. Present only with `COUNTDOWN_SEG_EN`.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- **Reset:** state IDLE; digits equal `START_MIN`, `START_SEC/10`, `START_SEC%10`.
  - `running`, `expired` and `expire_pulse` are 0.
  - `hex*` show the start digits.
- **Input priority per cycle:** `clear` > `pause` > `start` > `tick`. `reset` overrides all inputs.
- **`clear`:** from any state, go to IDLE and reload the start digits. `expire_pulse` is 0.
- **IDLE:**
  - `start` with start value ≠ 0:00 → RUN.
  - `start` with start value = 0:00 → EXPIRED, with `expire_pulse`.
  - `tick` is ignored.
- **RUN:**
  - `pause` → PAUSE; a `tick` in the same cycle is dropped.
  - Otherwise `tick` decrements the value by one second.
- **PAUSE:**
  - `start` → RUN; a `tick` in the same cycle is dropped.
  - `tick` is ignored; the value holds.
- **EXPIRED:** value holds at 0:00; `start`, `pause` and `tick` are ignored. Exit only via `clear` or `reset`.
- **Decrement (BCD, no binary conversion):**
  - ones ≠ 0: ones−1.
  - ones = 0, tens ≠ 0: ones=9, tens−1.
  - ones = 0, tens = 0, min ≠ 0: ones=9, tens=5, min−1.
- **Expiry:** a decrement that produces 0:00 moves to EXPIRED on the same edge. `expire_pulse`=1 for that one cycle only, and the digits read 0:00 in the same cycle.
- Digits never wrap below 0:00, and never leave the BCD ranges above.

## Timing
- Latency: input sampled at edge N → state, digits and flags updated after edge N.
- `running` and `expired` are decoded from registered state and are valid the cycle after the transition.
- `tick` is assumed to be one cycle wide; a tick held for k cycles causes k decrements in RUN.
- `hex*` are registered alongside the digits, with zero additional latency relative to the BCD outputs.
- `reset` asserted mid-count returns to IDLE with start digits on the next edge.

## Configuration
- `COUNTDOWN_SEG_EN` defined:
  - Ports `hex2`, `hex1` and `hex0` exist.
  - Each is a registered active-low decode of its digit (0–9 standard patterns).
  - Values above 9 are unreachable and decode to all-off (7'h7F).
- `COUNTDOWN_SEG_EN` not defined: `hex*` ports and decoders are absent; BCD outputs are unchanged.

## Test plan
- **Basic count:** START=0:03; reset, `start`, three `tick`s spaced 5 cycles apart.
  - Digits go 0:02, 0:01, 0:00.
  - `expire_pulse`=1 for exactly one cycle on the third tick; `expired`=1 thereafter; `running`=0.
- **Borrow chain:** START=1:00; `start`, one `tick` → 0:59. Then 59 more ticks → 0:00 and EXPIRED.
- **Pause/resume:**
  - START=0:10; run 2 ticks → 0:08.
  - `pause` and `tick` in the same cycle → PAUSE, value 0:08.
  - 3 ticks while paused → still 0:08.
  - `start`, then a tick → 0:07.
- **Priority and clear:**
  - In RUN at 0:05, assert `clear`+`pause`+`tick` in one cycle → IDLE with start digits, `running`=0.
  - In EXPIRED, `start` is ignored; `clear` → IDLE.
- **Zero start:** START=0:00; `start` → EXPIRED next cycle, with a single `expire_pulse`.
- **Reset mid-run and segments:** with `COUNTDOWN_SEG_EN`, START=1:30, count to 1:27, assert `reset` for one cycle.
  - Digits return to 1:30; state is IDLE.
  - `hex2`=7'h79, `hex1`=7'h30, `hex0`=7'h40.
